// File: rtl/chan_packet_dram_lut_rd_ctrl.sv
// ---------------------------------------------------------------------------
// chan_packet_dram_lut_rd_ctrl
//
// Read-back controller for the channel-packet DRAM lookup table. A rising
// edge on the software start bit launches a counted burst of DRAM read
// commands. Each returned word is written into the LUT at its return index.
// A 32-bit status word reports done/busy/timeout/overrun and the returned
// count back to software.
//
// Ports:
//   user_clk, user_rst     : clock and synchronous active-high reset
//   start                  : software start level (rising edge acts)
//   base_addr, num_reads   : burst base address and length, latched on start
//   cmd_valid/addr/ready   : DRAM read command channel (valid/ready)
//   rd_valid, rd_data      : DRAM read-return strobe and data
//   lut_we/addr/data       : LUT write port (one pulse per counted return)
//   status                 : {done, busy, timeout, overrun, 12'b0, returned}
// ---------------------------------------------------------------------------
module chan_packet_dram_lut_rd_ctrl #(
    parameter int ADDR_W  = 24,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_reads,
    output logic              cmd_valid,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_ready,
    input  logic              rd_valid,
    input  logic [31:0]       rd_data,
    output logic              lut_we,
    output logic [CNT_W-1:0]  lut_addr,
    output logic [31:0]       lut_data,
    output logic [31:0]       status
);

    // The idle timer only has to reach TIMEOUT-1.
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              start_q;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  returned_q, returned_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              timeout_q, timeout_d;
    logic              overrun_q, overrun_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic              lut_we_q, lut_we_d;
    logic [CNT_W-1:0]  lut_addr_q, lut_addr_d;
    logic [31:0]       lut_data_q, lut_data_d;
    logic [31:0]       status_q, status_d;

    logic              start_evt_s;
    logic              busy_s;
    logic              clear_s;
    logic              hs_s;
    logic              rd_ok_s;
    logic              expire_s;
    logic [CNT_W-1:0]  issued_nx_s;
    logic [CNT_W-1:0]  returned_nx_s;

    // Event decode shared by the next-state and datapath logic.
    always_comb begin
        start_evt_s = start & ~start_q;
        busy_s      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        // Start events only act from IDLE or DONE.
        clear_s     = ~busy_s & start_evt_s;
        hs_s        = cmd_valid_q & cmd_ready;
        // Returns beyond the requested count are overruns, never written.
        rd_ok_s     = rd_valid & busy_s & (returned_q < num_q);
        if (hs_s) begin
            issued_nx_s = issued_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            issued_nx_s = issued_q;
        end
        if (rd_ok_s) begin
            returned_nx_s = returned_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            returned_nx_s = returned_q;
        end
        // Any handshake or counted return this cycle keeps the burst alive,
        // so a final return landing on the expiry cycle wins over timeout.
        expire_s = busy_s & ~hs_s & ~rd_ok_s & (timer_q == TMR_LAST);
    end

    // Next-state logic of the burst FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_evt_s) begin
                    if (num_reads == {CNT_W{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_ISSUE: begin
                if (hs_s && (issued_nx_s == num_q)) begin
                    // Last command and last return in one cycle skip DRAIN.
                    if (returned_nx_s == num_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (expire_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (returned_nx_s == num_q) begin
                    state_d = S_DONE;
                end else if (expire_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Burst counters, idle timer and sticky flags.
    always_comb begin
        base_d     = base_q;
        num_d      = num_q;
        issued_d   = issued_q;
        returned_d = returned_q;
        timer_d    = timer_q;
        timeout_d  = timeout_q;
        if (clear_s) begin
            base_d     = base_addr;
            num_d      = num_reads;
            issued_d   = {CNT_W{1'b0}};
            returned_d = {CNT_W{1'b0}};
            timer_d    = {TMR_W{1'b0}};
            timeout_d  = 1'b0;
        end else if (busy_s) begin
            issued_d   = issued_nx_s;
            returned_d = returned_nx_s;
            if (hs_s || rd_ok_s) begin
                timer_d = {TMR_W{1'b0}};
            end else if (expire_s) begin
                timeout_d = 1'b1;
            end else begin
                timer_d = timer_q + {{(TMR_W-1){1'b0}}, 1'b1};
            end
        end else begin
            timeout_d = timeout_q;
        end
        // An uncounted return always marks overrun, even on a start cycle.
        if (rd_valid && !rd_ok_s) begin
            overrun_d = 1'b1;
        end else if (clear_s) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Registered-output next values, derived from next state and counters.
    always_comb begin
        cmd_valid_d = (state_d == S_ISSUE);
        if (cmd_valid_d) begin
            // Address wraps modulo 2^ADDR_W by truncation.
            cmd_addr_d = base_d + ADDR_W'(issued_d);
        end else begin
            cmd_addr_d = cmd_addr_q;
        end
        lut_we_d = rd_ok_s;
        if (rd_ok_s) begin
            lut_addr_d = returned_q;
            lut_data_d = rd_data;
        end else begin
            lut_addr_d = lut_addr_q;
            lut_data_d = lut_data_q;
        end
        status_d = {(state_d == S_DONE),
                    ((state_d == S_ISSUE) || (state_d == S_DRAIN)),
                    timeout_d, overrun_d, 12'h000, 16'(returned_d)};
    end

    // State register.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            start_q     <= 1'b0;
            base_q      <= {ADDR_W{1'b0}};
            num_q       <= {CNT_W{1'b0}};
            issued_q    <= {CNT_W{1'b0}};
            returned_q  <= {CNT_W{1'b0}};
            timer_q     <= {TMR_W{1'b0}};
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= {ADDR_W{1'b0}};
            lut_we_q    <= 1'b0;
            lut_addr_q  <= {CNT_W{1'b0}};
            lut_data_q  <= 32'h0000_0000;
            status_q    <= 32'h0000_0000;
        end else begin
            start_q     <= start;
            base_q      <= base_d;
            num_q       <= num_d;
            issued_q    <= issued_d;
            returned_q  <= returned_d;
            timer_q     <= timer_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_addr_q  <= cmd_addr_d;
            lut_we_q    <= lut_we_d;
            lut_addr_q  <= lut_addr_d;
            lut_data_q  <= lut_data_d;
            status_q    <= status_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_addr  = cmd_addr_q;
    assign lut_we    = lut_we_q;
    assign lut_addr  = lut_addr_q;
    assign lut_data  = lut_data_q;
    assign status    = status_q;

endmodule

// File: tb/tb_chan_packet_dram_lut_rd_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for chan_packet_dram_lut_rd_ctrl. Inputs are driven and outputs
// sampled on the falling clock edge. A transaction-level model tracks the
// burst (issued/returned counts, idle cycles, flags) and predicts every
// command, LUT write and status word one cycle ahead.
// ---------------------------------------------------------------------------
module tb_chan_packet_dram_lut_rd_ctrl;

    localparam int TIMEOUT = 16;

    logic        user_clk;
    logic        user_rst;
    logic        start;
    logic [23:0] base_addr;
    logic [15:0] num_reads;
    logic        cmd_valid;
    logic [23:0] cmd_addr;
    logic        cmd_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        lut_we;
    logic [15:0] lut_addr;
    logic [31:0] lut_data;
    logic [31:0] status;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic        m_active, m_done, m_to, m_ov, m_start_prev, m_exp_we;
    int          m_issued, m_returned, m_num, m_idle;
    logic [23:0] m_base;
    logic [15:0] m_exp_la;
    logic [31:0] m_exp_ld, m_exp_status;
    logic [23:0] obs_addr[$];

    chan_packet_dram_lut_rd_ctrl #(
        .ADDR_W (24),
        .CNT_W  (16),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .user_clk (user_clk),
        .user_rst (user_rst),
        .start    (start),
        .base_addr(base_addr),
        .num_reads(num_reads),
        .cmd_valid(cmd_valid),
        .cmd_addr (cmd_addr),
        .cmd_ready(cmd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .lut_we   (lut_we),
        .lut_addr (lut_addr),
        .lut_data (lut_data),
        .status   (status)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_reset();
        m_active = 1'b0; m_done = 1'b0; m_to = 1'b0; m_ov = 1'b0;
        m_start_prev = 1'b0; m_exp_we = 1'b0;
        m_issued = 0; m_returned = 0; m_num = 0; m_idle = 0;
        m_base = 24'h000000; m_exp_la = 16'h0000; m_exp_ld = 32'h0;
        m_exp_status = 32'h0;
    endtask

    // One clock: check outputs against the model, drive inputs, advance model.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rd,
                        input logic st, output logic hs);
        logic counted, sevt, exp_cv;
        logic [23:0] exp_ca;
        @(negedge user_clk);
        exp_cv = m_active && (m_issued < m_num);
        exp_ca = m_base + 24'(m_issued);
        n_checks++;
        if (cmd_valid !== exp_cv) begin
            n_errors++;
            $display("FAIL cmd_valid @%0t got=%b exp=%b", $time, cmd_valid, exp_cv);
        end
        if (exp_cv) begin
            n_checks++;
            if (cmd_addr !== exp_ca) begin
                n_errors++;
                $display("FAIL cmd_addr @%0t got=%h exp=%h", $time, cmd_addr, exp_ca);
            end
        end
        n_checks++;
        if (lut_we !== m_exp_we) begin
            n_errors++;
            $display("FAIL lut_we @%0t got=%b exp=%b", $time, lut_we, m_exp_we);
        end
        if (m_exp_we) begin
            n_checks++;
            if (lut_addr !== m_exp_la || lut_data !== m_exp_ld) begin
                n_errors++;
                $display("FAIL lut_write @%0t got=%h/%h exp=%h/%h", $time,
                         lut_addr, lut_data, m_exp_la, m_exp_ld);
            end
        end
        n_checks++;
        if (status !== m_exp_status) begin
            n_errors++;
            $display("FAIL status @%0t got=%h exp=%h", $time, status, m_exp_status);
        end
        if (cmd_valid === 1'b1 && rdy) obs_addr.push_back(cmd_addr);

        user_rst = 1'b0; cmd_ready = rdy; rd_valid = rv; rd_data = rd; start = st;

        hs = exp_cv && rdy;
        counted = rv && m_active && (m_returned < m_num);
        sevt = st && !m_start_prev;
        m_start_prev = st;
        m_exp_we = counted; m_exp_la = 16'(m_returned); m_exp_ld = rd;
        if (!m_active && sevt) begin
            m_base = base_addr; m_num = int'(num_reads);
            m_issued = 0; m_returned = 0; m_to = 1'b0; m_ov = 1'b0; m_idle = 0;
            m_active = (m_num != 0); m_done = (m_num == 0);
        end else if (m_active) begin
            if (hs) m_issued++;
            if (counted) m_returned++;
            if (hs || counted) m_idle = 0;
            else m_idle++;
            if (m_issued == m_num && m_returned == m_num) begin
                m_active = 1'b0; m_done = 1'b1;
            end else if (m_idle == TIMEOUT) begin
                m_active = 1'b0; m_done = 1'b1; m_to = 1'b1;
            end
        end
        if (rv && !counted) m_ov = 1'b1;
        m_exp_status = {m_done, m_active, m_to, m_ov, 12'h000, 16'(m_returned)};
    endtask

    task automatic idle_step();
        logic hs;
        step(1'b0, 1'b0, 32'h0, 1'b0, hs);
    endtask

    task automatic apply_reset();
        @(negedge user_clk);
        user_rst = 1'b1; start = 1'b0; cmd_ready = 1'b0; rd_valid = 1'b0;
        model_reset();
    endtask

    // Start a burst and act as the DRAM: ready pattern per mode
    // (0 always, 1 toggling, 2 random), returns delivered in order after a
    // random latency, at most 'deliver' of them. stop_after>0 aborts early.
    task automatic run_burst(input logic [23:0] b, input int n, input int mode,
                             input int lat_lo, input int lat_hi, input int deliver,
                             input int stop_after, input logic poke_start);
        int q_t[$];
        int cyc, sent, last_t, t;
        logic hs, rdy, rv, st;
        base_addr = b; num_reads = 16'(n);
        obs_addr.delete();
        sent = 0; last_t = -1; cyc = 0;
        step(1'b0, 1'b0, 32'h0, 1'b1, hs);
        while (cyc < 400) begin
            if (stop_after > 0 && cyc >= stop_after) break;
            if (stop_after == 0 && !m_active && q_t.size() == 0) break;
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = (cyc % 2 == 0);
            else rdy = ($urandom_range(0, 3) != 0);
            rv = 1'b0;
            if (q_t.size() > 0 && q_t[0] <= cyc) begin
                void'(q_t.pop_front());
                rv = 1'b1;
            end
            st = poke_start && (cyc == 1);
            step(rdy, rv, $urandom, st, hs);
            if (hs && sent < deliver) begin
                t = cyc + int'($urandom_range(lat_lo, lat_hi));
                if (t <= last_t) t = last_t + 1;
                q_t.push_back(t);
                last_t = t;
                sent++;
            end
            cyc++;
        end
        if (stop_after == 0) begin
            n_checks++;
            if (m_active || q_t.size() != 0) begin
                n_errors++;
                $display("FAIL burst_budget got=active:%b pending:%0d exp=finished",
                         m_active, q_t.size());
            end
        end
    endtask

    task automatic check_status(input string name, input logic [31:0] exp);
        n_checks++;
        if (status !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", name, status, exp);
        end
    endtask

    task automatic check_addrs(input string name, input logic [23:0] b, input int n);
        logic [23:0] e;
        n_checks++;
        if (obs_addr.size() != n) begin
            n_errors++;
            $display("FAIL %s_count got=%0d exp=%0d", name, obs_addr.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                e = b + 24'(i);
                n_checks++;
                if (obs_addr[i] !== e) begin
                    n_errors++;
                    $display("FAIL %s_addr%0d got=%h exp=%h", name, i, obs_addr[i], e);
                end
            end
        end
    endtask

    task automatic test_reset();
        user_rst = 1'b1; start = 1'b0; cmd_ready = 1'b0; rd_valid = 1'b0;
        rd_data = 32'h0; base_addr = 24'h0; num_reads = 16'h0;
        model_reset();
        repeat (3) @(negedge user_clk);
        n_checks++;
        if ({cmd_valid, cmd_addr, lut_we, lut_addr, lut_data} !== 74'h0) begin
            n_errors++;
            $display("FAIL reset_outputs got=%b/%h/%b/%h/%h exp=all_zero",
                     cmd_valid, cmd_addr, lut_we, lut_addr, lut_data);
        end
        check_status("reset_status", 32'h0000_0000);
    endtask

    task automatic test_basic();
        run_burst(24'h000100, 4, 0, 3, 3, 4, 0, 1'b0);
        idle_step();
        check_addrs("basic", 24'h000100, 4);
        check_status("basic_status", 32'h8000_0004);
    endtask

    task automatic test_backpressure();
        run_burst(24'h00A000, 8, 1, 2, 2, 8, 0, 1'b0);
        idle_step();
        check_addrs("backpressure", 24'h00A000, 8);
        check_status("backpressure_status", 32'h8000_0008);
    endtask

    task automatic test_zero_count();
        run_burst(24'h123456, 0, 0, 1, 1, 0, 0, 1'b0);
        idle_step();
        idle_step();
        check_addrs("zero", 24'h000000, 0);
        check_status("zero_status", 32'h8000_0000);
    endtask

    task automatic test_timeout();
        run_burst(24'h000200, 5, 0, 3, 3, 3, 0, 1'b0);
        idle_step();
        check_status("timeout_status", 32'hA000_0003);
    endtask

    task automatic test_overrun();
        logic hs;
        run_burst(24'h000300, 4, 0, 2, 2, 4, 0, 1'b0);
        idle_step();
        check_status("overrun_pre", 32'h8000_0004);
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, hs);
        idle_step();
        check_status("overrun_done", 32'h9000_0004);
        apply_reset();
        idle_step();
        step(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, hs);
        idle_step();
        check_status("overrun_idle", 32'h1000_0000);
    endtask

    task automatic test_wrap_and_reset();
        logic hs;
        run_burst(24'hFFFFFE, 4, 0, 3, 3, 4, 0, 1'b0);
        idle_step();
        check_addrs("wrap", 24'hFFFFFE, 4);
        check_status("wrap_status", 32'h8000_0004);
        run_burst(24'h000400, 8, 0, 3, 3, 8, 5, 1'b0);
        apply_reset();
        @(negedge user_clk);
        n_checks++;
        if (status !== 32'h0 || cmd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset got=%h/%b exp=00000000/0", status, cmd_valid);
        end
        step(1'b0, 1'b1, 32'h0BAD_0BAD, 1'b0, hs);
        idle_step();
        check_status("late_return", 32'h1000_0000);
        run_burst(24'h000500, 3, 0, 1, 1, 3, 0, 1'b0);
        idle_step();
        check_addrs("restart", 24'h000500, 3);
        check_status("restart_status", 32'h8000_0003);
    endtask

    task automatic test_random();
        logic [23:0] b;
        int n;
        for (int k = 0; k < 6; k++) begin
            b = 24'($urandom);
            n = int'($urandom_range(1, 20));
            run_burst(b, n, 2, 1, 6, n, 0, 1'b1);
            idle_step();
            check_addrs("random", b, n);
            check_status("random_status", 32'h8000_0000 | 32'(n));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_count();
        test_timeout();
        test_overrun();
        test_wrap_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/chan_packet_dram_lut_rd_ctrl.md
# chan_packet_dram_lut_rd_ctrl

Read-back controller for the channel-packet DRAM lookup table. On a software start request it issues a counted burst of DRAM read commands, captures each returned word into the LUT write port, and maintains a 32-bit status word. The status word drives `user_data_in` of the `DRAM_LUT_rd_valid` software register, where the PowerPC polls completion, timeout and overrun.

## Interface
Parameters:
- `ADDR_W`, 24: DRAM command address width.
- `CNT_W`, 16: read-count width, fixed at 16 or less.
- `TIMEOUT`, 4096: idle cycles allowed without a handshake or return before the burst is aborted.

Ports:
- `user_clk` in 1: the single clock. All logic is synchronous to its rising edge.
- `user_rst` in 1: reset, synchronous and active-high.
- `start` in 1: software start bit. Level input; only its rising edge acts.
- `base_addr` in `ADDR_W`: first DRAM address, latched on start.
- `num_reads` in `CNT_W`: number of reads, latched on start.
- `cmd_valid` out 1: read command valid.
- `cmd_addr` out `ADDR_W`: read command address.
- `cmd_ready` in 1: DRAM accepts a command when `cmd_valid` and `cmd_ready` are both high.
- `rd_valid` in 1: DRAM read-return strobe.
- `rd_data` in 32: DRAM read-return data, qualified by `rd_valid`.
- `lut_we` out 1: LUT write enable.
- `lut_addr` out `CNT_W`: LUT write address, equal to the return index.
- `lut_data` out 32: LUT write data.
- `status` out 32: feeds the `rd_valid` software register.

## Operation
- **State machine:** IDLE, ISSUE, DRAIN, DONE.
- **Start detect:** `start_d` is a registered copy of `start`. A start event is `start & ~start_d`.
- **IDLE:**
  - On a start event, latch `base_addr` and `num_reads`.
  - Clear the issued count, the returned count, the timeout flag, the overrun flag and the idle timer.
  - If the latched count is 0, go to DONE. Otherwise go to ISSUE.
- **ISSUE:**
  - `cmd_valid` = 1 and `cmd_addr` = base + issued, modulo 2^`ADDR_W`. The address wraps silently.
  - Each handshake increments the issued count.
  - The handshake that makes issued equal to num moves the FSM to DRAIN. `cmd_valid` is low from the next cycle.
- **Return path (ISSUE and DRAIN):**
  - `rd_valid` while returned < num: write `lut_addr` = returned and `lut_data` = `rd_data`, then increment returned.
  - Returns may begin before issuing completes.
- **DRAIN:** when returned reaches num, go to DONE.
- **Overrun:** `rd_valid` in IDLE or DONE, or while returned == num, sets a sticky overrun flag. That return is neither written nor counted.
- **Timeout:**
  - The idle timer counts only in ISSUE and DRAIN.
  - It clears on any command handshake or counted `rd_valid`.
  - On reaching `TIMEOUT`-1, set the timeout flag and go to DONE. The returned count freezes at its current value.
- **DONE:**
  - Flags and count hold.
  - A new start event restarts the burst exactly as from IDLE.
  - Start events in ISSUE and DRAIN are ignored.
- **Status word:**
  - [31] done (state is DONE).
  - [30] busy (state is ISSUE or DRAIN).
  - [29] timeout.
  - [28] overrun.
  - [27:16] zero.
  - [15:0] returned count, zero-extended.
- **Reset:** state goes to IDLE. All outputs are 0, including `cmd_addr`, `lut_addr`, `lut_data` and `status`. Reset mid-burst aborts immediately; outstanding DRAM returns that arrive after reset are flagged only as overrun.

## Timing
- **Start to command:** start rising at cycle N (sampled) → FSM leaves IDLE at N+1 → `cmd_valid` high at N+1.
- **Command signals:** `cmd_valid` and `cmd_addr` are registered. After a handshake, the next address is presented in the following cycle, so one command per cycle is possible while `cmd_ready` stays high.
- **LUT write latency:** `rd_valid` at cycle M → `lut_we`, `lut_addr` and `lut_data` registered at M+1. `lut_we` is a single-cycle pulse per return.
- **Status latency:** `status` is registered and reflects state and counters one cycle after the event that changes them. The done bit rises one cycle after the final counted return is sampled.
- **Last return vs timeout:** if the final return and timeout expiry fall in the same cycle, the return wins. The return is counted, the timeout flag stays clear, and the FSM goes to DONE.
- **Last return vs final handshake:** if the last handshake and the last return fall in the same cycle, go directly to DONE.
- **Throughput:** full rate, one return per cycle, with no back-pressure on `rd_valid`.

## Test plan
- **Basic burst:** base 0x000100, num 4, `cmd_ready` tied high, returns 3 cycles after each command → addresses 0x100–0x103, LUT writes at 0–3 with matching data, status 0x80000004.
- **Back-pressure:** `cmd_ready` toggles 1010…, num 8 → exactly 8 handshakes, consecutive addresses, no duplicates, status 0x80000008.
- **Zero count:** num 0 → no `cmd_valid` pulse, status 0x80000000 two cycles after the start edge.
- **Timeout:** num 5, only 3 returns delivered, `TIMEOUT`=16 → status 0xA0000003 after 16 idle cycles.
- **Overrun:** an extra `rd_valid` after completion, and one during IDLE → bit 28 set, count unchanged, no `lut_we` pulse.
- **Wrap and reset:** base 0xFFFFFE, num 4 → addresses FFFFFE, FFFFFF, 000000, 000001. Asserting `user_rst` mid-burst → `status`=0 and `cmd_valid`=0 the next cycle. A new start then runs cleanly.
